prf_free_list: RTL and testbench

//   Circular free list of physical register tags for the rename stage. Supplies up to DEQ_WIDTH

---
 rtl/prf_free_list_if.sv | 41 ++++
 rtl/prf_free_list.sv | 158 +++++++++++++++
 tb/tb_prf_free_list.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prf_free_list_if.sv
// prf_free_list_if
//   Bundles the rename-side dequeue port and the commit-side enqueue port of the
//   physical register free list.
//
//   Handshake: rename raises deq_req_mask bits for the ways that want a tag.
//   Grants happen only in a cycle where deq_ready=1, and then all requested ways
//   are granted at that posedge. With deq_ready=0 the request is ignored and
//   rename must hold it.
//   Commit raises enq_valid_mask bits with the matching enq_PR_by_way lanes.
//   Commit is never back-pressured; an enqueue the list cannot hold sets error.
//
//   master : rename + commit side (drives requests and returned tags)
//   slave  : free list (drives grants, count and error)
interface prf_free_list_if #(
  parameter int PR_COUNT       = 128,
  parameter int ARCH_REG_COUNT = 32,
  parameter int DEQ_WIDTH      = 4,
  parameter int ENQ_WIDTH      = 4
);
  localparam int LOG_PR_COUNT = $clog2(PR_COUNT);
  localparam int DEPTH        = PR_COUNT - ARCH_REG_COUNT;
  localparam int CNT_W        = $clog2(DEPTH + 1);

  logic [DEQ_WIDTH-1:0]              deq_req_mask;
  logic                              deq_ready;
  logic [DEQ_WIDTH*LOG_PR_COUNT-1:0] deq_PR_by_way;
  logic [ENQ_WIDTH-1:0]              enq_valid_mask;
  logic [ENQ_WIDTH*LOG_PR_COUNT-1:0] enq_PR_by_way;
  logic [CNT_W-1:0]                  free_count;
  logic                              error;

  modport master (
    output deq_req_mask, enq_valid_mask, enq_PR_by_way,
    input  deq_ready, deq_PR_by_way, free_count, error
  );

  modport slave (
    input  deq_req_mask, enq_valid_mask, enq_PR_by_way,
    output deq_ready, deq_PR_by_way, free_count, error
  );
endinterface

// File: rtl/prf_free_list.sv
// prf_free_list
//   Circular free list of physical register tags. Hands out up to DEQ_WIDTH free
//   tags per cycle to rename and takes back up to ENQ_WIDTH tags per cycle from
//   commit. At reset the list holds tags ARCH_REG_COUNT..PR_COUNT-1 in order.
//
//   Ports:
//     CLK   : clock, all state updates on posedge
//     nRST  : asynchronous active-low reset
//     fl    : prf_free_list_if.slave (dequeue grants, enqueue, free_count, error)
//
//   Optional build macro FREE_LIST_DUP_CHECK_EN adds a per-tag is_free vector so
//   that returning a tag that is already free is dropped and flagged on error.
//   Without it, error reports overflow only.
module prf_free_list #(
  parameter int PR_COUNT       = 128,
  parameter int ARCH_REG_COUNT = 32,
  parameter int DEQ_WIDTH      = 4,
  parameter int ENQ_WIDTH      = 4
) (
  input  logic           CLK,
  input  logic           nRST,
  prf_free_list_if.slave fl
);
  localparam int LOG_PR_COUNT = $clog2(PR_COUNT);
  localparam int DEPTH        = PR_COUNT - ARCH_REG_COUNT;
  localparam int PTR_W        = $clog2(DEPTH);
  localparam int CNT_W        = $clog2(DEPTH + 1);

  typedef logic [LOG_PR_COUNT-1:0] tag_t;
  typedef logic [PTR_W-1:0]        ptr_t;
  typedef logic [CNT_W-1:0]        cnt_t;

  tag_t r_mem [DEPTH];
  ptr_t r_head;
  ptr_t r_tail;
  cnt_t r_count;
  logic r_error;

  // DEPTH need not be a power of two, so wrap by compare. n is always < DEPTH.
  function automatic ptr_t wrap_add(input ptr_t p, input cnt_t n);
    int s;
    s = int'(p) + int'(n);
    if (s >= DEPTH) s = s - DEPTH;
    return ptr_t'(s);
  endfunction

  // ---------------- dequeue ----------------
  tag_t w_deq_tag [DEQ_WIDTH];
  cnt_t w_deq_n;
  logic w_deq_ready;
  logic w_deq_fire;
  cnt_t w_deq_granted;

  // Way k reads head + number of requesting ways below it.
  always_comb begin
    w_deq_n = '0;
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      w_deq_tag[k] = r_mem[wrap_add(r_head, w_deq_n)];
      if (fl.deq_req_mask[k]) w_deq_n = w_deq_n + cnt_t'(1);
    end
  end

  // Ready is all-or-nothing: fewer than DEQ_WIDTH free stalls every way.
  assign w_deq_ready   = (r_count >= cnt_t'(DEQ_WIDTH));
  assign w_deq_fire    = w_deq_ready && (|fl.deq_req_mask);
  assign w_deq_granted = w_deq_fire ? w_deq_n : '0;

  for (genvar k = 0; k < DEQ_WIDTH; k++) begin : g_deq_out
    assign fl.deq_PR_by_way[k*LOG_PR_COUNT +: LOG_PR_COUNT] = w_deq_tag[k];
  end

  assign fl.deq_ready  = w_deq_ready;
  assign fl.free_count = r_count;
  assign fl.error      = r_error;

  // ---------------- enqueue ----------------
  logic [ENQ_WIDTH-1:0] w_enq_acc;
  ptr_t                 w_enq_idx [ENQ_WIDTH];
  tag_t                 w_enq_tag [ENQ_WIDTH];
  cnt_t                 w_enq_n;
  cnt_t                 w_space;
  logic                 w_enq_err;
  logic                 w_dup;

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [PR_COUNT-1:0] r_is_free;
  logic [PR_COUNT-1:0] w_free_scan;
`endif

  // Space is measured before this cycle's dequeue: slots freed by a grant are
  // not reusable until the next cycle.
  assign w_space = cnt_t'(DEPTH) - r_count;

  // Accepted ways are compacted in way order starting at tail. With the
  // duplicate check, the scan vector sees this cycle's grants cleared first
  // and earlier accepted ways set, so two ways returning one tag flag the second.
  always_comb begin
    w_enq_n   = '0;
    w_enq_err = 1'b0;
    w_enq_acc = '0;
    w_dup     = 1'b0;
`ifdef FREE_LIST_DUP_CHECK_EN
    w_free_scan = r_is_free;
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      if (w_deq_fire && fl.deq_req_mask[k]) w_free_scan[w_deq_tag[k]] = 1'b0;
    end
`endif
    for (int j = 0; j < ENQ_WIDTH; j++) begin
      w_enq_tag[j] = fl.enq_PR_by_way[j*LOG_PR_COUNT +: LOG_PR_COUNT];
      w_enq_idx[j] = wrap_add(r_tail, w_enq_n);
      w_dup        = 1'b0;
      if (fl.enq_valid_mask[j]) begin
`ifdef FREE_LIST_DUP_CHECK_EN
        w_dup = w_free_scan[w_enq_tag[j]];
`endif
        if (w_dup || (w_enq_n == w_space)) begin
          w_enq_err = 1'b1;
        end else begin
          w_enq_acc[j] = 1'b1;
          w_enq_n      = w_enq_n + cnt_t'(1);
`ifdef FREE_LIST_DUP_CHECK_EN
          w_free_scan[w_enq_tag[j]] = 1'b1;
`endif
        end
      end
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= tag_t'(ARCH_REG_COUNT + i);
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= cnt_t'(DEPTH);
      r_error <= 1'b0;
    end else begin
      for (int j = 0; j < ENQ_WIDTH; j++) begin
        if (w_enq_acc[j]) r_mem[w_enq_idx[j]] <= w_enq_tag[j];
      end
      if (w_deq_fire) r_head <= wrap_add(r_head, w_deq_n);
      r_tail  <= wrap_add(r_tail, w_enq_n);
      r_count <= r_count + w_enq_n - w_deq_granted;
      if (w_enq_err) r_error <= 1'b1;
    end
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < PR_COUNT; i++) r_is_free[i] <= (i >= ARCH_REG_COUNT);
    end else begin
      r_is_free <= w_free_scan;
    end
  end
`endif

endmodule

// File: tb/tb_prf_free_list.sv
module tb_prf_free_list;
  localparam int PR_COUNT = 128;
  localparam int ARCH     = 32;
  localparam int DW       = 4;
  localparam int EW       = 4;
  localparam int TAG_W    = $clog2(PR_COUNT);
  localparam int DEPTH    = PR_COUNT - ARCH;
`ifdef FREE_LIST_DUP_CHECK_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CLK;
  logic nRST;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  prf_free_list_if #(.PR_COUNT(PR_COUNT), .ARCH_REG_COUNT(ARCH),
                     .DEQ_WIDTH(DW), .ENQ_WIDTH(EW)) bus ();

  prf_free_list #(.PR_COUNT(PR_COUNT), .ARCH_REG_COUNT(ARCH),
                  .DEQ_WIDTH(DW), .ENQ_WIDTH(EW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .fl   (bus)
  );

  // ---------------- scoreboard / reference model ----------------
  int tests  = 0;
  int failed = 0;

  int mq[$];               // free list contents, head first
  bit mfree [PR_COUNT];
  bit merr;
  int held[$];             // tags handed out and not yet returned

  typedef struct {
    logic [DW-1:0]       dm;
    logic [EW-1:0]       em;
    logic [EW*TAG_W-1:0] etags;
    logic                exp_ready;
    int                  exp_count;
    logic                exp_err;
    logic [DW*TAG_W-1:0] exp_tags;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW*TAG_W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [EW*TAG_W-1:0] r;
    r = '0;
    r[0*TAG_W +: TAG_W] = a[TAG_W-1:0];
    r[1*TAG_W +: TAG_W] = b[TAG_W-1:0];
    r[2*TAG_W +: TAG_W] = c[TAG_W-1:0];
    r[3*TAG_W +: TAG_W] = d[TAG_W-1:0];
    return r;
  endfunction

  function automatic int dut_tag(input int k);
    return int'(bus.deq_PR_by_way[k*TAG_W +: TAG_W]);
  endfunction

  task automatic model_reset();
    mq.delete();
    held.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back(ARCH + i);
    for (int i = 0; i < PR_COUNT; i++) mfree[i] = (i >= ARCH);
    merr = 1'b0;
  endtask

  task automatic model_update(input logic [DW-1:0] dm, input logic [EW-1:0] em,
                              input logic [EW*TAG_W-1:0] tags);
    int size0;
    int acc;
    int t;
    size0 = mq.size();
    if (size0 >= DW && dm != '0) begin
      for (int k = 0; k < DW; k++) begin
        if (dm[k]) begin
          t = mq.pop_front();
          mfree[t] = 1'b0;
          held.push_back(t);
        end
      end
    end
    acc = 0;
    for (int j = 0; j < EW; j++) begin
      if (em[j]) begin
        t = int'(tags[j*TAG_W +: TAG_W]);
        if ((DUP && mfree[t]) || acc == DEPTH - size0) begin
          merr = 1'b1;
        end else begin
          mq.push_back(t);
          mfree[t] = 1'b1;
          acc++;
        end
      end
    end
  endtask

  task automatic check_model(input logic [DW-1:0] dm);
    int pos;
    chk("deq_ready", 32'(bus.deq_ready), 32'(mq.size() >= DW));
    chk("free_count", 32'(bus.free_count), 32'(mq.size()));
    chk("error", 32'(bus.error), 32'(merr));
    pos = 0;
    for (int k = 0; k < DW; k++) begin
      if (dm[k]) begin
        if (pos < mq.size()) chk($sformatf("deq_tag_way%0d", k), 32'(dut_tag(k)), 32'(mq[pos]));
        pos++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    nRST = 1'b0;
    bus.deq_req_mask   = '0;
    bus.enq_valid_mask = '0;
    bus.enq_PR_by_way  = '0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic apply(input logic [DW-1:0] dm, input logic [EW-1:0] em,
                       input logic [EW*TAG_W-1:0] tags);
    @(negedge CLK);
    bus.deq_req_mask   = dm;
    bus.enq_valid_mask = em;
    bus.enq_PR_by_way  = tags;
    #1;
  endtask

  task automatic commit(input logic [DW-1:0] dm, input logic [EW-1:0] em,
                        input logic [EW*TAG_W-1:0] tags);
    @(posedge CLK);
    model_update(dm, em, tags);
  endtask

  task automatic step(input logic [DW-1:0] dm, input logic [EW-1:0] em,
                      input logic [EW*TAG_W-1:0] tags);
    apply(dm, em, tags);
    check_model(dm);
    commit(dm, em, tags);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [DW-1:0]       rdm;
    logic [EW-1:0]       rem;
    logic [EW*TAG_W-1:0] rtags;
    int                  idx;

    nRST = 1'b0;
    bus.deq_req_mask   = '0;
    bus.enq_valid_mask = '0;
    bus.enq_PR_by_way  = '0;

    // Expected values worked out by hand from the reset image 32..127.
    vecs[0] = '{4'b1111, 4'b0000, pack4(0,0,0,0),     1'b1, 96, 1'b0, pack4(32,33,34,35)};
    vecs[1] = '{4'b1010, 4'b0000, pack4(0,0,0,0),     1'b1, 92, 1'b0, pack4(0,36,0,37)};
    vecs[2] = '{4'b0000, 4'b0011, pack4(33,35,0,0),   1'b1, 90, 1'b0, pack4(0,0,0,0)};
    vecs[3] = '{4'b0001, 4'b0000, pack4(0,0,0,0),     1'b1, 92, 1'b0, pack4(38,0,0,0)};
    vecs[4] = '{4'b1111, 4'b1111, pack4(32,34,36,37), 1'b1, 91, 1'b0, pack4(39,40,41,42)};
    vecs[5] = '{4'b0000, 4'b0000, pack4(0,0,0,0),     1'b1, 91, 1'b0, pack4(0,0,0,0)};

    do_reset();
    for (int v = 0; v < 6; v++) begin
      apply(vecs[v].dm, vecs[v].em, vecs[v].etags);
      chk($sformatf("vec%0d_ready", v), 32'(bus.deq_ready), 32'(vecs[v].exp_ready));
      chk($sformatf("vec%0d_count", v), 32'(bus.free_count), 32'(vecs[v].exp_count));
      chk($sformatf("vec%0d_error", v), 32'(bus.error), 32'(vecs[v].exp_err));
      for (int k = 0; k < DW; k++) begin
        if (vecs[v].dm[k])
          chk($sformatf("vec%0d_way%0d", v, k), 32'(dut_tag(k)),
              32'(vecs[v].exp_tags[k*TAG_W +: TAG_W]));
      end
      commit(vecs[v].dm, vecs[v].em, vecs[v].etags);
    end

    // Sparse request right after reset.
    do_reset();
    apply(4'b1010, '0, '0);
    chk("sparse_way1", 32'(dut_tag(1)), 32'd32);
    chk("sparse_way3", 32'(dut_tag(3)), 32'd33);
    commit(4'b1010, '0, '0);
    apply('0, '0, '0);
    chk("sparse_count", 32'(bus.free_count), 32'd94);
    commit('0, '0, '0);

    // Drain below DEQ_WIDTH, then same-cycle enqueue with a stalled dequeue.
    do_reset();
    for (int i = 0; i < 23; i++) step(4'b1111, '0, '0);
    step(4'b0001, '0, '0);
    apply(4'b0001, '0, '0);
    chk("low_ready", 32'(bus.deq_ready), 32'd0);
    chk("low_count", 32'(bus.free_count), 32'd3);
    commit(4'b0001, '0, '0);
    apply(4'b1111, 4'b0101, pack4(5, 0, 9, 0));
    chk("low_count_hold", 32'(bus.free_count), 32'd3);
    chk("low_ready_hold", 32'(bus.deq_ready), 32'd0);
    commit(4'b1111, 4'b0101, pack4(5, 0, 9, 0));
    apply(4'b1111, '0, '0);
    chk("refill_count", 32'(bus.free_count), 32'd5);
    chk("refill_ready", 32'(bus.deq_ready), 32'd1);
    chk("refill_way0", 32'(dut_tag(0)), 32'd125);
    chk("refill_way1", 32'(dut_tag(1)), 32'd126);
    chk("refill_way2", 32'(dut_tag(2)), 32'd127);
    chk("refill_way3", 32'(dut_tag(3)), 32'd5);
    commit(4'b1111, '0, '0);
    apply(4'b0001, '0, '0);
    chk("refill_tail_tag", 32'(dut_tag(0)), 32'd9);
    chk("refill_tail_count", 32'(bus.free_count), 32'd1);
    commit(4'b0001, '0, '0);

    // Overflow on a full list; error is sticky until reset.
    do_reset();
    step('0, 4'b0001, pack4(7, 0, 0, 0));
    apply('0, '0, '0);
    chk("ovf_count", 32'(bus.free_count), 32'd96);
    chk("ovf_error", 32'(bus.error), 32'd1);
    commit('0, '0, '0);
    step(4'b1111, '0, '0);
    apply('0, '0, '0);
    chk("ovf_sticky", 32'(bus.error), 32'd1);
    commit('0, '0, '0);
    do_reset();
    apply('0, '0, '0);
    chk("ovf_cleared", 32'(bus.error), 32'd0);
    commit('0, '0, '0);

    // Return of a tag that is still free.
    do_reset();
    step(4'b1111, '0, '0);
    step('0, 4'b0001, pack4(40, 0, 0, 0));
    apply('0, '0, '0);
    chk("dup_error", 32'(bus.error), 32'(DUP));
    chk("dup_count", 32'(bus.free_count), DUP ? 32'd92 : 32'd93);
    commit('0, '0, '0);

    // Random traffic: returns come from tags previously handed out, so the
    // pointers wrap many times around the 96-entry ring.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rdm   = DW'($urandom_range(0, (1 << DW) - 1));
      rem   = '0;
      rtags = '0;
      for (int j = 0; j < EW; j++) begin
        if (held.size() > 0 && $urandom_range(0, 2) != 0) begin
          idx = $urandom_range(0, held.size() - 1);
          rem[j] = 1'b1;
          rtags[j*TAG_W +: TAG_W] = held[idx][TAG_W-1:0];
          held.delete(idx);
        end
      end
      step(rdm, rem, rtags);
    end

    // Asynchronous reset in the middle of a request.
    apply(4'b1111, 4'b0011, pack4(3, 4, 0, 0));
    nRST = 1'b0;
    #1;
    model_reset();
    chk("midrst_count", 32'(bus.free_count), 32'd96);
    chk("midrst_way0", 32'(dut_tag(0)), 32'd32);
    chk("midrst_way3", 32'(dut_tag(3)), 32'd35);
    chk("midrst_error", 32'(bus.error), 32'd0);
    @(negedge CLK);
    bus.deq_req_mask   = '0;
    bus.enq_valid_mask = '0;
    nRST = 1'b1;
    step(4'b1111, '0, '0);
    step('0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
